// File: rtl/uart_rx_buffered.sv
// UART receive channel: baud-tick divider, rx synchroniser, runtime frame format,
// and a first-word-fall-through FIFO holding {break,frame,parity,data} per character.
module uart_rx_buffered #(
    parameter int DATA_W       = 8,
    parameter int OVERSAMPLE   = 16,
    parameter int FIFO_ADDR_W  = 4,
    parameter int DIV_W        = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   rx,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       divisor,
    input  logic [1:0]             data_len,
    input  logic [1:0]             parity_mode,
    input  logic                   stop_bits,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic [2:0]             rd_err,
    output logic                   empty,
    output logic                   full,
    output logic [FIFO_ADDR_W:0]   level,
    output logic                   overrun,
    output logic                   timeout,
    output logic                   rx_active
);

    localparam int OS_W   = $clog2(OVERSAMPLE);
    localparam int DEPTH  = 1 << FIFO_ADDR_W;
    localparam int ENT_W  = DATA_W + 3;
    localparam int TO_LIM = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TO_W   = $clog2(TO_LIM + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
    } state_t;

    logic               r_rx_meta, r_rx_sync;
    logic [DIV_W-1:0]   r_div;
    logic               w_tick;
    state_t             r_state, w_nxt;
    logic [OS_W-1:0]    r_cnt, w_cnt_nxt;
    logic [3:0]         r_bit, w_bit_nxt, w_len;
    logic [DATA_W-1:0]  r_shift, w_shift_nxt, w_algn;
    logic               r_zero, w_zero_nxt;
    logic               r_par_err, w_par_nxt;
    logic               r_frm, w_frm_nxt;
    logic               r_stop, w_stop_nxt;
    logic               w_push, w_start, w_brk;
    logic               w_mid, w_end, w_par_en, w_frm_fin;
    logic [ENT_W-1:0]   w_wdata;
    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_ADDR_W:0]   r_level;
    logic               w_empty, w_full, w_pop, w_wr;
    logic               r_ovr;
    logic [TO_W-1:0]    r_to;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_div     <= '0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_div     <= w_tick ? '0 : r_div + 1'b1;
        end
    end

    // >= keeps the divider from running away when divisor is lowered mid-count
    assign w_tick   = (r_div >= divisor);
    assign w_mid    = (r_cnt == OS_W'(OVERSAMPLE / 2 - 1));
    assign w_end    = (r_cnt == OS_W'(OVERSAMPLE - 1));
    assign w_par_en = parity_mode[0] ^ parity_mode[1];
    assign w_algn   = r_shift >> (4'(DATA_W) - w_len);
    assign w_frm_fin = r_frm | ~r_rx_sync;
    assign w_wdata  = {w_brk, w_frm_fin, r_par_err, w_algn};

    always_comb begin
        w_len = 4'(data_len) + 4'd5;
        if (w_len > 4'(DATA_W))
            w_len = 4'(DATA_W);
    end

    always_comb begin
        w_nxt       = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_zero_nxt  = r_zero;
        w_par_nxt   = r_par_err;
        w_frm_nxt   = r_frm;
        w_stop_nxt  = r_stop;
        w_push      = 1'b0;
        w_start     = 1'b0;
        w_brk       = 1'b0;
        if (!enable) begin
            w_nxt = S_IDLE;
        end else if (w_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!r_rx_sync) begin
                        w_nxt       = S_START;
                        w_start     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_shift_nxt = '0;
                        w_zero_nxt  = 1'b1;
                        w_par_nxt   = 1'b0;
                        w_frm_nxt   = 1'b0;
                        w_stop_nxt  = 1'b0;
                    end
                end
                S_START: begin
                    if (w_mid) begin
                        w_cnt_nxt = '0;
                        w_nxt     = r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_end) begin
                        w_cnt_nxt   = '0;
                        w_shift_nxt = {r_rx_sync, r_shift[DATA_W-1:1]};
                        w_bit_nxt   = r_bit + 4'd1;
                        if (r_rx_sync)
                            w_zero_nxt = 1'b0;
                        if (r_bit + 4'd1 == w_len)
                            w_nxt = w_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_end) begin
                        w_cnt_nxt = '0;
                        w_par_nxt = (^r_shift ^ r_rx_sync) != parity_mode[0];
                        w_nxt     = S_STOP;
                        if (r_rx_sync)
                            w_zero_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_end) begin
                        w_cnt_nxt = '0;
                        w_frm_nxt = w_frm_fin;
                        if (r_rx_sync)
                            w_zero_nxt = 1'b0;
                        if (stop_bits && !r_stop) begin
                            w_stop_nxt = 1'b1;
                        end else begin
                            w_push = 1'b1;
                            w_brk  = r_zero & ~r_rx_sync;
                            w_nxt  = w_brk ? S_BRK : S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_BRK: begin
                    if (r_rx_sync)
                        w_nxt = S_IDLE;
                end
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_zero    <= 1'b0;
            r_par_err <= 1'b0;
            r_frm     <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_zero    <= w_zero_nxt;
            r_par_err <= w_par_nxt;
            r_frm     <= w_frm_nxt;
            r_stop    <= w_stop_nxt;
        end
    end

    // level never exceeds DEPTH, so its MSB alone marks full
    assign w_empty = (r_level == '0);
    assign w_full  = r_level[FIFO_ADDR_W];
    assign w_pop   = rd_en & ~w_empty;
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge PCLK) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)
                r_level <= r_level + 1'b1;
            else if (!w_wr && w_pop)
                r_level <= r_level - 1'b1;
            r_ovr <= w_push & w_full & ~w_pop;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_to <= '0;
        else if (w_pop || w_empty || w_start)
            r_to <= '0;
        else if (w_tick && r_state == S_IDLE && r_to != TO_W'(TO_LIM))
            r_to <= r_to + 1'b1;
    end

    assign rd_data   = w_empty ? '0 : r_mem[r_rd_ptr][DATA_W-1:0];
    assign rd_err    = w_empty ? '0 : r_mem[r_rd_ptr][ENT_W-1:DATA_W];
    assign empty     = w_empty;
    assign full      = w_full;
    assign level     = r_level;
    assign overrun   = r_ovr;
    assign timeout   = (r_to == TO_W'(TO_LIM));
    assign rx_active = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: frame-format vector table plus FIFO, break,
// glitch, timeout and reset sequences, checked against a scoreboard queue.
module tb_uart_rx_buffered;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        rx = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] divisor = '0;
    logic [1:0]  data_len = 2'd3;
    logic [1:0]  parity_mode = 2'd0;
    logic        stop_bits = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic [2:0]  rd_err;
    logic        empty, full, overrun, timeout, rx_active;
    logic [4:0]  level;

    int n_chk = 0;
    int n_fail = 0;
    int ovr_cnt = 0;
    logic [10:0] sb[$];

    uart_rx_buffered dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .rx(rx), .enable(enable),
        .divisor(divisor), .data_len(data_len), .parity_mode(parity_mode),
        .stop_bits(stop_bits), .rd_en(rd_en), .rd_data(rd_data),
        .rd_err(rd_err), .empty(empty), .full(full), .level(level),
        .overrun(overrun), .timeout(timeout), .rx_active(rx_active)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK)
        if (overrun) ovr_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] div;
        logic [7:0]  d;
        logic [1:0]  len;
        logic [1:0]  pm;
        logic        two;
        logic        pflip;
        logic        sbad;
        logic [7:0]  ed;
        logic [2:0]  ee;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called right after a negedge; rx changes on negedges only.
    task automatic send_char(input logic [7:0] d, input int nbits,
                             input logic [1:0] pm, input logic two,
                             input logic pflip, input logic sbad);
        int bc;
        logic [7:0] m;
        logic p;
        bc = 16 * (int'(divisor) + 1);
        m = 8'hFF >> (8 - nbits);
        rx = 1'b0;
        repeat (bc) @(negedge PCLK);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            repeat (bc) @(negedge PCLK);
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            p = ^(d & m);
            if (pm == 2'b01) p = ~p;
            rx = p ^ pflip;
            repeat (bc) @(negedge PCLK);
        end
        rx = ~sbad;
        repeat (bc) @(negedge PCLK);
        if (two) begin
            rx = 1'b1;
            repeat (bc) @(negedge PCLK);
        end
        rx = 1'b1;
    endtask

    task automatic wait_ne(input string name);
        int k;
        k = 0;
        while (empty && k < 4000) begin
            @(negedge PCLK);
            k++;
        end
        check({name, " not-empty"}, empty, 0);
    endtask

    task automatic pop_check(input string name);
        logic [10:0] e;
        wait_ne(name);
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard has no entry", name);
        end else begin
            e = sb.pop_front();
            check({name, " data"}, rd_data, e[7:0]);
            check({name, " err"}, rd_err, e[10:8]);
        end
        rd_en = 1'b1;
        @(negedge PCLK);
        rd_en = 1'b0;
    endtask

    task automatic cfg8n1();
        divisor = 16'd0;
        data_len = 2'd3;
        parity_mode = 2'd0;
        stop_bits = 1'b0;
    endtask

    initial begin
        int ovr0;
        vt[0]  = '{16'd0, 8'hA5, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 8'hA5, 3'b000};
        vt[1]  = '{16'd0, 8'h41, 2'd2, 2'b10, 1'b0, 1'b1, 1'b0, 8'h41, 3'b001};
        vt[2]  = '{16'd0, 8'h41, 2'd2, 2'b10, 1'b0, 1'b0, 1'b0, 8'h41, 3'b000};
        vt[3]  = '{16'd0, 8'h41, 2'd2, 2'b01, 1'b0, 1'b0, 1'b0, 8'h41, 3'b000};
        vt[4]  = '{16'd0, 8'h1F, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h1F, 3'b000};
        vt[5]  = '{16'd0, 8'h3C, 2'd1, 2'b11, 1'b0, 1'b0, 1'b1, 8'h3C, 3'b010};
        vt[6]  = '{16'd0, 8'hFF, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h1F, 3'b000};
        vt[7]  = '{16'd0, 8'h5A, 2'd3, 2'b01, 1'b1, 1'b0, 1'b1, 8'h5A, 3'b010};
        vt[8]  = '{16'd2, 8'hA5, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 8'hA5, 3'b000};
        vt[9]  = '{16'd0, 8'hC3, 2'd3, 2'b11, 1'b0, 1'b0, 1'b0, 8'hC3, 3'b000};
        vt[10] = '{16'd0, 8'h00, 2'd3, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000};
        vt[11] = '{16'd0, 8'h00, 2'd3, 2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 3'b110};

        repeat (3) @(negedge PCLK);
        check("reset empty", empty, 1);
        check("reset level", level, 0);
        check("reset full", full, 0);
        check("reset rd_data", rd_data, 0);
        check("reset rd_err", rd_err, 0);
        check("reset active", rx_active, 0);
        check("reset timeout", timeout, 0);
        check("reset overrun", overrun, 0);
        PRESETn = 1'b1;
        enable = 1'b1;
        repeat (4) @(negedge PCLK);

        for (int i = 0; i < 12; i++) begin
            divisor = vt[i].div;
            data_len = vt[i].len;
            parity_mode = vt[i].pm;
            stop_bits = vt[i].two;
            repeat (4) @(negedge PCLK);
            sb.push_back({vt[i].ee, vt[i].ed});
            send_char(vt[i].d, int'(vt[i].len) + 5, vt[i].pm, vt[i].two,
                      vt[i].pflip, vt[i].sbad);
            repeat (40) @(negedge PCLK);
            check($sformatf("vec%0d level", i), level, 1);
            pop_check($sformatf("vec%0d", i));
            check($sformatf("vec%0d empty after pop", i), empty, 1);
        end

        // push latency and idle timeout
        cfg8n1();
        repeat (20) @(negedge PCLK);
        sb.push_back({3'b000, 8'hA5});
        fork
            send_char(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b0);
            begin
                repeat (154) @(negedge PCLK);
                check("latency empty before", empty, 1);
                @(negedge PCLK);
                check("latency empty after", empty, 0);
                check("latency level", level, 1);
                repeat (505) @(negedge PCLK);
                check("timeout early", timeout, 0);
                repeat (8) @(negedge PCLK);
                check("timeout rise", timeout, 1);
            end
        join
        check("timeout held", timeout, 1);
        pop_check("timeout char");
        check("timeout cleared", timeout, 0);

        // start-bit glitch
        rx = 1'b0;
        repeat (3) @(negedge PCLK);
        rx = 1'b1;
        check("glitch active", rx_active, 1);
        repeat (30) @(negedge PCLK);
        check("glitch idle", rx_active, 0);
        check("glitch empty", empty, 1);

        // line break
        sb.push_back({3'b110, 8'h00});
        rx = 1'b0;
        repeat (320) @(negedge PCLK);
        check("break level low", level, 1);
        check("break waiting", rx_active, 1);
        rx = 1'b1;
        repeat (40) @(negedge PCLK);
        check("break level high", level, 1);
        check("break idle", rx_active, 0);
        pop_check("break");

        // fill, overrun, push with simultaneous pop
        for (int j = 0; j < 16; j++) begin
            sb.push_back({3'b000, 8'h10 + 8'(j)});
            send_char(8'h10 + 8'(j), 8, 2'b00, 1'b0, 1'b0, 1'b0);
            repeat (20) @(negedge PCLK);
        end
        check("fill full", full, 1);
        check("fill level", level, 16);
        check("fill no overrun", ovr_cnt, 0);
        ovr0 = ovr_cnt;
        send_char(8'hEE, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge PCLK);
        check("overrun pulse", ovr_cnt, ovr0 + 1);
        check("overrun level", level, 16);
        check("overrun head", rd_data, 8'h10);
        fork
            send_char(8'h77, 8, 2'b00, 1'b0, 1'b0, 1'b0);
            begin
                logic [10:0] e;
                repeat (154) @(negedge PCLK);
                e = sb.pop_front();
                check("pop+push head", rd_data, e[7:0]);
                rd_en = 1'b1;
                @(negedge PCLK);
                rd_en = 1'b0;
            end
        join
        sb.push_back({3'b000, 8'h77});
        repeat (20) @(negedge PCLK);
        check("pop+push level", level, 16);
        check("pop+push no overrun", ovr_cnt, ovr0 + 1);
        check("pop+push new head", rd_data, 8'h11);
        for (int j = 0; j < 16; j++)
            pop_check($sformatf("drain%0d", j));
        check("drain empty", empty, 1);
        check("drain level", level, 0);

        // reset in the middle of a character
        sb.push_back({3'b000, 8'h3C});
        send_char(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge PCLK);
        rx = 1'b0;
        repeat (48) @(negedge PCLK);
        check("pre-reset active", rx_active, 1);
        PRESETn = 1'b0;
        #1;
        check("mid reset empty", empty, 1);
        check("mid reset level", level, 0);
        check("mid reset data", rd_data, 0);
        check("mid reset active", rx_active, 0);
        check("mid reset timeout", timeout, 0);
        sb.delete();
        @(negedge PCLK);
        rx = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (20) @(negedge PCLK);
        check("post reset empty", empty, 1);
        sb.push_back({3'b000, 8'h96});
        send_char(8'h96, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge PCLK);
        check("post reset level", level, 1);
        pop_check("post reset");
        check("final empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
